// File: rtl/l1_coherence_agent.sv
// Per-core MESI agent: turns L1 requests into bus transactions
// and answers bus snoops against the L1 tag/state array.
module l1_coherence_agent #(
  parameter int BLOCK_SIZE = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     l1_req_valid,
  input  logic [1:0]               l1_req_type,
  input  logic [31:0]              l1_req_addr,
  input  logic [32*BLOCK_SIZE-1:0] l1_req_data,
  output logic                     l1_req_ready,
  output logic                     l1_fill_valid,
  output logic [32*BLOCK_SIZE-1:0] l1_fill_data,
  output logic [1:0]               l1_fill_state,
  output logic                     snp_lookup,
  output logic [31:0]              snp_addr,
  input  logic [1:0]               snp_state,
  input  logic [32*BLOCK_SIZE-1:0] snp_data,
  output logic                     snp_upd,
  output logic [1:0]               snp_upd_state,
  output logic                     dREN,
  output logic                     dWEN,
  output logic                     ccwrite,
  output logic [31:0]              daddr,
  output logic [32*BLOCK_SIZE-1:0] dstore,
  input  logic                     dwait,
  input  logic [32*BLOCK_SIZE-1:0] dload,
  input  logic                     ccexclusive,
  input  logic                     ccwait,
  input  logic                     ccinv,
  input  logic [31:0]              ccsnoopaddr,
  output logic                     snoopdone,
  output logic                     ccsnoophit,
  output logic                     ccIsPresent,
  output logic                     ccdirty
);

  localparam int BW = 32 * BLOCK_SIZE;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] T_RD  = 2'b00;
  localparam logic [1:0] T_RDX = 2'b01;
  localparam logic [1:0] T_UPG = 2'b10;
  localparam logic [1:0] T_EVC = 2'b11;

  typedef enum logic [1:0] {
    RQ_IDLE,
    RQ_BUS,
    RQ_DONE
  } rq_t;

  typedef enum logic [2:0] {
    SN_IDLE,
    SN_LOOKUP,
    SN_CAPTURE,
    SN_RESP,
    SN_UPDATE
  } sn_t;

  rq_t           rq_state, rq_next;
  logic [1:0]    rq_type;
  logic [31:0]   rq_addr;
  logic [BW-1:0] rq_data;
  logic [BW-1:0] fill_data_q;
  logic [1:0]    fill_state_q;
  logic [1:0]    fill_state_d;
  logic          rq_evict;

  sn_t           sn_state, sn_next;
  logic [31:0]   sn_addr;
  logic [1:0]    sn_st;
  logic [BW-1:0] sn_data;
  logic          sn_inv;
  logic          sn_resp;

  always_comb begin
    fill_state_d = ST_I;
    unique case (rq_type)
      T_RD:    fill_state_d = ccexclusive ? ST_E : ST_S;
      T_RDX:   fill_state_d = ST_M;
      T_UPG:   fill_state_d = ST_M;
      default: fill_state_d = ST_I;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rq_state     <= RQ_IDLE;
      rq_type      <= T_RD;
      rq_addr      <= '0;
      rq_data      <= '0;
      fill_data_q  <= '0;
      fill_state_q <= ST_I;
    end else begin
      rq_state <= rq_next;
      if (rq_state == RQ_IDLE && l1_req_valid) begin
        rq_type <= l1_req_type;
        rq_addr <= l1_req_addr & ~32'h7;
        rq_data <= l1_req_data;
      end
      if (rq_state == RQ_BUS && !dwait) begin
        fill_data_q  <= dload;
        fill_state_q <= fill_state_d;
      end
    end
  end

  // Ready is masked by reset so every output reads 0 while nRST is low.
  always_comb begin
    rq_next       = rq_state;
    l1_req_ready  = 1'b0;
    l1_fill_valid = 1'b0;
    dREN          = 1'b0;
    dWEN          = 1'b0;
    ccwrite       = 1'b0;
    daddr         = '0;
    rq_evict      = 1'b0;
    unique case (rq_state)
      RQ_IDLE: begin
        l1_req_ready = nRST;
        if (l1_req_valid) rq_next = RQ_BUS;
      end
      RQ_BUS: begin
        daddr    = rq_addr;
        dREN     = (rq_type == T_RD) || (rq_type == T_RDX);
        ccwrite  = (rq_type == T_RDX) || (rq_type == T_UPG);
        dWEN     = (rq_type == T_EVC);
        rq_evict = (rq_type == T_EVC);
        if (!dwait) rq_next = RQ_DONE;
      end
      RQ_DONE: begin
        l1_fill_valid = 1'b1;
        rq_next       = RQ_IDLE;
      end
      default: rq_next = RQ_IDLE;
    endcase
  end

  assign l1_fill_data  = fill_data_q;
  assign l1_fill_state = fill_state_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sn_state <= SN_IDLE;
      sn_addr  <= '0;
      sn_st    <= ST_I;
      sn_data  <= '0;
      sn_inv   <= 1'b0;
    end else begin
      sn_state <= sn_next;
      unique case (sn_state)
        SN_IDLE: begin
          if (ccwait) sn_addr <= ccsnoopaddr & ~32'h7;
          sn_inv <= 1'b0;
        end
        SN_LOOKUP: begin
          if (ccinv) sn_inv <= 1'b1;
        end
        SN_CAPTURE: begin
          sn_st   <= snp_state;
          sn_data <= snp_data;
          if (ccinv) sn_inv <= 1'b1;
        end
        SN_RESP: begin
          if (ccinv) sn_inv <= 1'b1;
        end
        SN_UPDATE: begin
          sn_addr <= '0;
          sn_st   <= ST_I;
          sn_data <= '0;
          sn_inv  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sn_next       = sn_state;
    sn_resp       = 1'b0;
    snp_lookup    = 1'b0;
    snp_addr      = '0;
    snp_upd       = 1'b0;
    snp_upd_state = ST_I;
    snoopdone     = 1'b0;
    ccsnoophit    = 1'b0;
    ccIsPresent   = 1'b0;
    ccdirty       = 1'b0;
    unique case (sn_state)
      SN_IDLE: begin
        if (ccwait) sn_next = SN_LOOKUP;
      end
      SN_LOOKUP: begin
        snp_lookup = 1'b1;
        snp_addr   = sn_addr;
        sn_next    = SN_CAPTURE;
      end
      SN_CAPTURE: sn_next = SN_RESP;
      SN_RESP: begin
        sn_resp     = 1'b1;
        snoopdone   = 1'b1;
        ccsnoophit  = sn_st[1];
        ccIsPresent = (sn_st != ST_I);
        ccdirty     = (sn_st == ST_M);
        if (!ccwait) sn_next = SN_UPDATE;
      end
      SN_UPDATE: begin
        snp_addr = sn_addr;
        if (sn_st != ST_I) begin
          if (sn_inv) begin
            snp_upd       = 1'b1;
            snp_upd_state = ST_I;
          end else if (sn_st[1]) begin
            snp_upd       = 1'b1;
            snp_upd_state = ST_S;
          end
        end
        sn_next = SN_IDLE;
      end
      default: sn_next = SN_IDLE;
    endcase
  end

  // Snoop supply data overrides evict data on the shared bus.
  always_comb begin
    dstore = '0;
    if (sn_resp) dstore = sn_data;
    else if (rq_evict) dstore = rq_data;
  end

  a_dstore_conflict: assert property (
    @(posedge CLK) disable iff (!nRST)
    !(sn_resp && rq_evict));

  a_req_during_update: assert property (
    @(posedge CLK) disable iff (!nRST)
    !(l1_req_valid && rq_state == RQ_IDLE &&
      sn_state == SN_UPDATE &&
      l1_req_addr[31:3] == sn_addr[31:3]));

endmodule

// File: tb/tb_l1_coherence_agent.sv
// Directed vector bench for l1_coherence_agent: request table,
// snoop table, concurrency and mid-transaction reset.
module tb_l1_coherence_agent;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        l1_req_valid;
  logic [1:0]  l1_req_type;
  logic [31:0] l1_req_addr;
  logic [63:0] l1_req_data;
  logic        l1_req_ready;
  logic        l1_fill_valid;
  logic [63:0] l1_fill_data;
  logic [1:0]  l1_fill_state;
  logic        snp_lookup;
  logic [31:0] snp_addr;
  logic [1:0]  snp_state;
  logic [63:0] snp_data;
  logic        snp_upd;
  logic [1:0]  snp_upd_state;
  logic        dREN, dWEN, ccwrite;
  logic [31:0] daddr;
  logic [63:0] dstore;
  logic        dwait;
  logic [63:0] dload;
  logic        ccexclusive;
  logic        ccwait, ccinv;
  logic [31:0] ccsnoopaddr;
  logic        snoopdone, ccsnoophit, ccIsPresent, ccdirty;

  always #5 CLK = ~CLK;

  l1_coherence_agent #(.BLOCK_SIZE(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .l1_req_valid(l1_req_valid), .l1_req_type(l1_req_type),
    .l1_req_addr(l1_req_addr), .l1_req_data(l1_req_data),
    .l1_req_ready(l1_req_ready), .l1_fill_valid(l1_fill_valid),
    .l1_fill_data(l1_fill_data), .l1_fill_state(l1_fill_state),
    .snp_lookup(snp_lookup), .snp_addr(snp_addr),
    .snp_state(snp_state), .snp_data(snp_data),
    .snp_upd(snp_upd), .snp_upd_state(snp_upd_state),
    .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite),
    .daddr(daddr), .dstore(dstore), .dwait(dwait),
    .dload(dload), .ccexclusive(ccexclusive),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .snoopdone(snoopdone), .ccsnoophit(ccsnoophit),
    .ccIsPresent(ccIsPresent), .ccdirty(ccdirty)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [63:0] data;
    logic [63:0] load;
    logic        excl;
    logic [1:0]  st;
    logic        ren, wen, ccw;
    logic [31:0] daddr;
  } rq_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  st;
    logic [63:0] data;
    logic        inv;
    logic        hit, pres, dirty, upd;
    logic [1:0]  ust;
  } sn_vec_t;

  int vec  = 0;
  int errs = 0;
  rq_vec_t rq_tab[6];
  sn_vec_t sn_tab[7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rq_start(input rq_vec_t v);
    l1_req_valid = 1'b1;
    l1_req_type  = v.typ;
    l1_req_addr  = v.addr;
    l1_req_data  = v.data;
    chk("ready_idle", 64'(l1_req_ready), 64'd1);
    step();
    l1_req_valid = 1'b0;
    chk("ready_busy", 64'(l1_req_ready), 64'd0);
    chk("dREN", 64'(dREN), 64'(v.ren));
    chk("dWEN", 64'(dWEN), 64'(v.wen));
    chk("ccwrite", 64'(ccwrite), 64'(v.ccw));
    chk("daddr", 64'(daddr), 64'(v.daddr));
    chk("dstore_rq", dstore, v.wen ? v.data : 64'd0);
  endtask

  task automatic rq_finish(input rq_vec_t v);
    chk("dREN_hold", 64'(dREN), 64'(v.ren));
    chk("fill_early", 64'(l1_fill_valid), 64'd0);
    dwait       = 1'b0;
    dload       = v.load;
    ccexclusive = v.excl;
    step();
    dwait       = 1'b1;
    dload       = '0;
    ccexclusive = 1'b0;
    chk("fill_valid", 64'(l1_fill_valid), 64'd1);
    chk("fill_state", 64'(l1_fill_state), 64'(v.st));
    if (v.typ == 2'b00 || v.typ == 2'b01)
      chk("fill_data", l1_fill_data, v.load);
    chk("lines_drop",
        64'({dREN, dWEN, ccwrite}), 64'd0);
    chk("daddr_drop", 64'(daddr), 64'd0);
    step();
    chk("fill_pulse", 64'(l1_fill_valid), 64'd0);
    chk("ready_back", 64'(l1_req_ready), 64'd1);
  endtask

  task automatic run_snoop(input sn_vec_t v);
    ccwait      = 1'b1;
    ccinv       = v.inv;
    ccsnoopaddr = v.addr;
    step();
    chk("snp_lookup", 64'(snp_lookup), 64'd1);
    chk("snp_addr", 64'(snp_addr),
        64'(v.addr & ~32'h7));
    chk("sd_early", 64'(snoopdone), 64'd0);
    snp_state = v.st;
    snp_data  = v.data;
    step();
    chk("lookup_pulse", 64'(snp_lookup), 64'd0);
    chk("sd_early2", 64'(snoopdone), 64'd0);
    step();
    snp_state = 2'b00;
    snp_data  = '0;
    chk("snoopdone", 64'(snoopdone), 64'd1);
    chk("snoophit", 64'(ccsnoophit), 64'(v.hit));
    chk("present", 64'(ccIsPresent), 64'(v.pres));
    chk("dirty", 64'(ccdirty), 64'(v.dirty));
    chk("dstore_sn", dstore, v.data);
    step();
    chk("sd_hold", 64'(snoopdone), 64'd1);
    chk("hit_hold", 64'(ccsnoophit), 64'(v.hit));
    chk("upd_early", 64'(snp_upd), 64'd0);
    ccwait = 1'b0;
    step();
    ccinv = 1'b0;
    chk("snp_upd", 64'(snp_upd), 64'(v.upd));
    if (v.upd) begin
      chk("upd_state", 64'(snp_upd_state), 64'(v.ust));
      chk("upd_addr", 64'(snp_addr),
          64'(v.addr & ~32'h7));
    end
    chk("sd_drop", 64'(snoopdone), 64'd0);
    step();
    chk("upd_pulse", 64'(snp_upd), 64'd0);
    chk("resp_clear",
        64'({snoopdone, ccsnoophit, ccIsPresent, ccdirty}),
        64'd0);
  endtask

  initial begin
    rq_tab[0] = '{2'b00, 32'h0000_2008, 64'h0,
      64'hDEAD_BEEF_0123_4567, 1'b1, 2'b10,
      1'b1, 1'b0, 1'b0, 32'h0000_2008};
    rq_tab[1] = '{2'b00, 32'h0000_300C, 64'h0,
      64'h1111_2222_3333_4444, 1'b0, 2'b01,
      1'b1, 1'b0, 1'b0, 32'h0000_3008};
    rq_tab[2] = '{2'b01, 32'h0000_4001, 64'h0,
      64'h5555_6666_7777_8888, 1'b0, 2'b11,
      1'b1, 1'b0, 1'b1, 32'h0000_4000};
    rq_tab[3] = '{2'b10, 32'h0000_5007, 64'h0,
      64'h0, 1'b1, 2'b11,
      1'b0, 1'b0, 1'b1, 32'h0000_5000};
    rq_tab[4] = '{2'b11, 32'h0000_1004,
      64'hCAFE_F00D_0BAD_BEEF, 64'h0, 1'b1, 2'b00,
      1'b0, 1'b1, 1'b0, 32'h0000_1000};
    rq_tab[5] = '{2'b01, 32'hFFFF_FFFF, 64'h0,
      64'h0123_4567_89AB_CDEF, 1'b1, 2'b11,
      1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8};

    sn_tab[0] = '{32'h0000_6000, 2'b11, 64'hA5A5,
      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
    sn_tab[1] = '{32'h0000_6108, 2'b01, 64'h1234,
      1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
    sn_tab[2] = '{32'h0000_6210, 2'b00, 64'h0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
    sn_tab[3] = '{32'h0000_6315, 2'b10, 64'h7777,
      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    sn_tab[4] = '{32'h0000_6418, 2'b11, 64'h9999,
      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00};
    sn_tab[5] = '{32'h0000_6520, 2'b01, 64'h4242,
      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
    sn_tab[6] = '{32'h0000_6628, 2'b00, 64'h0,
      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

    nRST         = 1'b0;
    l1_req_valid = 1'b0;
    l1_req_type  = 2'b00;
    l1_req_addr  = '0;
    l1_req_data  = '0;
    snp_state    = 2'b00;
    snp_data     = '0;
    dwait        = 1'b1;
    dload        = '0;
    ccexclusive  = 1'b0;
    ccwait       = 1'b0;
    ccinv        = 1'b0;
    ccsnoopaddr  = '0;
    #3;
    chk("rst_ready", 64'(l1_req_ready), 64'd0);
    chk("rst_lines", 64'({dREN, dWEN, ccwrite,
        l1_fill_valid, snp_lookup, snp_upd,
        snoopdone, ccsnoophit, ccIsPresent, ccdirty}),
        64'd0);
    chk("rst_buses", 64'(daddr | snp_addr), 64'd0);
    chk("rst_dstore", dstore, 64'd0);
    step();
    step();
    nRST = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      rq_start(rq_tab[i]);
      step();
      rq_finish(rq_tab[i]);
    end

    for (int i = 0; i < 7; i++) run_snoop(sn_tab[i]);

    // Snoop while an own read sits on the bus.
    rq_start(rq_tab[1]);
    run_snoop(sn_tab[0]);
    rq_finish(rq_tab[1]);

    // Reset while the read is waiting on the bus.
    rq_start(rq_tab[0]);
    chk("pre_rst_dREN", 64'(dREN), 64'd1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_dREN", 64'(dREN), 64'd0);
    chk("mid_rst_daddr", 64'(daddr), 64'd0);
    chk("mid_rst_ready", 64'(l1_req_ready), 64'd0);
    chk("mid_rst_fill", 64'(l1_fill_valid), 64'd0);
    step();
    nRST = 1'b1;
    #1;
    chk("post_rst_ready", 64'(l1_req_ready), 64'd1);
    step();
    chk("post_rst_idle", 64'({dREN, l1_fill_valid}), 64'd0);
    rq_start(rq_tab[0]);
    step();
    rq_finish(rq_tab[0]);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
